// File: rtl/sqrt_fixed_iter.sv
// sqrt_fixed_iter: iterative radix-2 non-restoring square root for signed Q(INT.FRAC).
// One root bit retires per clock. No multiplier is used.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake. x is sampled only on the acceptance edge.
//   x                    signed Q(INT.FRAC) operand
//   out_valid/out_ready  result handshake. The result is held until it is consumed.
//   sqrt                 Q(INT.FRAC) root: floor(sqrt(x)*2^FRAC) in raw units, or rounded
//   err                  operand was negative (sqrt=0). Qualified by out_valid.
module sqrt_fixed_iter #(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int ROUND_MODE = 0,
    localparam int W     = INT_WIDTH + FRAC_WIDTH,
    localparam int RAD_W = ((W + FRAC_WIDTH + 1) / 2) * 2,
    localparam int ITER  = RAD_W / 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sqrt,
    output logic         err
);
    localparam int RW = ITER + 2;            // signed partial remainder width
    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 state;
    logic [RAD_W-1:0]       rad;             // radicand, consumed two bits per step from the top
    logic signed [RW-1:0]   rem;
    logic [ITER-1:0]        root;
    logic [CW-1:0]          cnt;

    logic signed [RW-1:0]   rem_sh, rem_nxt, rem_fix;
    logic [ITER-1:0]        root_nxt;
    logic                   rnd_up;
    logic [W-1:0]           result;

    // One non-restoring step: the sign of the running remainder decides
    // whether to subtract (4*root+1) or add back (4*root+3).
    always_comb begin
        rem_sh = {rem[RW-3:0], rad[RAD_W-1 -: 2]};
        if (!rem[RW-1])
            rem_nxt = rem_sh - {root, 2'b01};
        else
            rem_nxt = rem_sh + {root, 2'b11};
        root_nxt = {root[ITER-2:0], ~rem_nxt[RW-1]};
        // A negative final remainder is restored to R - root^2 before rounding.
        rem_fix = rem_nxt[RW-1] ? rem_nxt + {1'b0, root_nxt, 1'b1} : rem_nxt;
        // rem > root means R > (root+0.5)^2; equality is impossible for integers.
        rnd_up  = (ROUND_MODE != 0) && (rem_fix > $signed({2'b00, root_nxt}));
        result  = W'(root_nxt) + W'(rnd_up);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sqrt      <= '0;
            err       <= 1'b0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is registered, so it rises one edge after reset release.
                    if (!in_ready) begin
                        in_ready <= 1'b1;
                    end else if (in_valid) begin
                        in_ready <= 1'b0;
                        if (x[W-1]) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            err       <= 1'b1;
                            sqrt      <= '0;
                        end else begin
                            rad   <= RAD_W'({x, {FRAC_WIDTH{1'b0}}});
                            rem   <= '0;
                            root  <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rad  <= rad << 2;
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sqrt      <= result;
                        err       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
